// File: rtl/pipereg_skid.sv
// ---------------------------------------------------------------------------
// pipereg_skid
//
// Pipeline stage register with a valid/ready handshake and a 2-entry skid
// buffer. It replaces the fixed IF/ID, ID/EXE, ... stage registers of the
// RV32IMC core. It adds back-pressure at full throughput, and in_ready is
// driven straight from a flop, so there is no combinational path from
// out_ready to in_ready.
//
// Parameters
//   DATA_W     width of the packed stage payload
//   CNT_W      stall-counter width (used only with PIPEREG_STALL_CNT_EN)
//
// Ports
//   clk        clock, all state updates on posedge
//   nrst       synchronous active-low reset
//   flush      synchronous squash of all held entries (inserts a zero bubble)
//   in_valid   upstream payload valid
//   in_ready   stage can accept (registered)
//   in_data    upstream payload
//   out_valid  downstream payload valid
//   out_ready  downstream accepts
//   out_data   downstream payload (all zero while out_valid = 0)
//   stall_cnt  saturating count of stalled cycles (PIPEREG_STALL_CNT_EN only)
//
// Configuration
//   PIPEREG_STALL_CNT_EN : when defined, adds the stall_cnt port and counter.
//                          The handshake path is the same in both builds.
// ---------------------------------------------------------------------------
module pipereg_skid #(
  parameter int unsigned DATA_W = 96,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPEREG_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  // Elaboration-time sanity checks on the configuration.
  if (DATA_W < 1) begin : g_bad_data_w
    $error("pipereg_skid: DATA_W must be at least 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("pipereg_skid: CNT_W must be at least 1");
  end

  // Occupancy is fully defined by the two valid bits. The value "skid only"
  // cannot be reached, because the skid slot fills only while main is valid.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  logic              m_v;
  logic [DATA_W-1:0] m_d;
  logic              s_v;
  logic [DATA_W-1:0] s_d;

  occ_e occ;
  logic in_fire;
  logic out_fire;

  assign out_valid = m_v;
  assign out_data  = m_d;
  assign in_ready  = ~s_v;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = m_v & out_ready;

  always_comb begin
    occ = OCC_EMPTY;
    if (s_v)      occ = OCC_FULL;
    else if (m_v) occ = OCC_ONE;
  end

  // Data registers are cleared whenever their slot goes invalid. This keeps
  // out_data at zero (a NOP bubble) without an output mux.
  always_ff @(posedge clk) begin
    if (!nrst || flush) begin
      m_v <= 1'b0;
      m_d <= '0;
      s_v <= 1'b0;
      s_d <= '0;
    end else begin
      unique case (occ)
        OCC_FULL: begin
          // in_ready is low here, so upstream cannot fire. Only the drain
          // from skid into main can happen.
          if (out_fire) begin
            m_v <= 1'b1;
            m_d <= s_d;
            s_v <= 1'b0;
            s_d <= '0;
          end
        end
        OCC_ONE: begin
          if (out_fire) begin
            if (in_fire) begin
              m_v <= 1'b1;
              m_d <= in_data;
            end else begin
              m_v <= 1'b0;
              m_d <= '0;
            end
          end else if (in_fire) begin
            // The downstream stage is stalled, so the new beat goes into skid.
            s_v <= 1'b1;
            s_d <= in_data;
          end
        end
        default: begin
          if (in_fire) begin
            m_v <= 1'b1;
            m_d <= in_data;
          end else begin
            m_v <= 1'b0;
            m_d <= '0;
          end
        end
      endcase
    end
  end

`ifdef PIPEREG_STALL_CNT_EN
  // Counts cycles in which a valid beat waits on downstream. Flush does not
  // clear it, so stalls stay visible across pipeline squashes.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      stall_cnt <= '0;
    end else if (m_v && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipereg_skid.sv
// ---------------------------------------------------------------------------
// tb_pipereg_skid
//
// Self-checking bench for pipereg_skid. The reference is a bounded FIFO of
// depth 2, plus a saturating stall counter. Directed scenarios pin the
// reference with literal values, and a randomized phase with occasional
// flush and reset follows.
// Build with +define+PIPEREG_STALL_CNT_EN to also check stall_cnt.
// ---------------------------------------------------------------------------
module tb_pipereg_skid;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          nrst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
`ifdef PIPEREG_STALL_CNT_EN
  logic [CW-1:0] stall_cnt;
`endif

  pipereg_skid #(
    .DATA_W(DW),
    .CNT_W (CW)
  ) dut (
    .clk      (clk),
    .nrst     (nrst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef PIPEREG_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned passes = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Reference model: a FIFO of at most 2 beats, with a saturating counter.
  logic [DW-1:0] q[$];
  int unsigned   m_cnt = 0;
  bit            known = 1'b0;
  bit            hold_req = 1'b0;
  localparam int unsigned CNT_MAX = (1 << CW) - 1;

  always @(posedge clk) begin
    bit ifire, ofire, stalled;
    ifire   = in_valid && (q.size() < 2);
    ofire   = (q.size() > 0) && out_ready;
    stalled = (q.size() > 0) && !out_ready;
    hold_req = nrst && !flush && in_valid && !(q.size() < 2);
    if (!nrst) begin
      q.delete();
      m_cnt = 0;
      known = 1'b1;
    end else begin
      if (stalled && m_cnt < CNT_MAX) m_cnt++;
      if (flush) begin
        q.delete();
      end else begin
        if (ofire) void'(q.pop_front());
        if (ifire) q.push_back(in_data);
      end
    end
  end

  // Compare the DUT against the model on every cycle after the first reset.
  always @(negedge clk) begin
    if (known) begin
      logic [DW-1:0] exp_d;
      exp_d = (q.size() > 0) ? q[0] : '0;
      chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
      chk("out_data", 64'(out_data), 64'(exp_d));
      chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
`ifdef PIPEREG_STALL_CNT_EN
      chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
`endif
    end
  end

  // Advance one clock and return at the following negedge, where outputs
  // are settled.
  task automatic next();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    nrst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset
    next(); next();
    nrst = 1'b1;
    next();
    chk("t1_out_valid", 64'(out_valid), 64'd0);
    chk("t1_out_data", 64'(out_data), 64'd0);
    chk("t1_in_ready", 64'(in_ready), 64'd1);
`ifdef PIPEREG_STALL_CNT_EN
    chk("t1_stall_cnt", 64'(stall_cnt), 64'd0);
`endif

    // Streaming
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i);
      next();
      chk("t2_out_valid", 64'(out_valid), 64'd1);
      chk("t2_out_data", 64'(out_data), 64'(i));
      chk("t2_in_ready", 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    next();
    chk("t2_drained", 64'(out_valid), 64'd0);

    // Back-pressure
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 'hA;
    next();
    chk("t3_main_a", 64'(out_data), 64'hA);
    chk("t3_ready_one", 64'(in_ready), 64'd1);
    in_data = 'hB;
    next();
    chk("t3_main_a_full", 64'(out_data), 64'hA);
    chk("t3_ready_full", 64'(in_ready), 64'd0);
    in_data = 'hC;
    next();
    chk("t3_still_a", 64'(out_data), 64'hA);
    chk("t3_c_held", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    next();
    chk("t3_out_b", 64'(out_data), 64'hB);
    chk("t3_ready_back", 64'(in_ready), 64'd1);
    next();
    chk("t3_out_c", 64'(out_data), 64'hC);
    in_valid = 1'b0;
    next();
    chk("t3_empty_v", 64'(out_valid), 64'd0);
    chk("t3_empty_d", 64'(out_data), 64'd0);

    // Flush while FULL, with a same-cycle input
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 'h1A;
    next();
    in_data = 'h1B;
    next();
    flush = 1'b1; in_data = 'hD;
    next();
    chk("t4_flush_v", 64'(out_valid), 64'd0);
    chk("t4_flush_d", 64'(out_data), 64'd0);
    chk("t4_flush_rdy", 64'(in_ready), 64'd1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    next();
    chk("t4_no_d", 64'(out_valid), 64'd0);

    // Reset in the middle of a stall
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 'h21;
    next();
    in_data = 'h22;
    next();
    in_valid = 1'b0; nrst = 1'b0;
    next();
    chk("t5_rst_v", 64'(out_valid), 64'd0);
    chk("t5_rst_d", 64'(out_data), 64'd0);
    chk("t5_rst_rdy", 64'(in_ready), 64'd1);
    nrst = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 'h31;
    next();
    chk("t5_resume_a", 64'(out_data), 64'h31);
    in_data = 'h32;
    next();
    chk("t5_resume_b", 64'(out_data), 64'h32);
    in_valid = 1'b0;
    next();

    // Stall counter saturation
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 'h44;
    next();
    in_valid = 1'b0;
    repeat (20) next();
    chk("t6_main_held", 64'(out_data), 64'h44);
`ifdef PIPEREG_STALL_CNT_EN
    chk("t6_saturated", 64'(stall_cnt), 64'd15);
`endif
    flush = 1'b1;
    next();
    flush = 1'b0;
    next();
    chk("t6_flushed", 64'(out_valid), 64'd0);
`ifdef PIPEREG_STALL_CNT_EN
    chk("t6_kept", 64'(stall_cnt), 64'd15);
`endif

    // Randomized traffic; upstream holds a beat that was not accepted.
    for (int n = 0; n < 3000; n++) begin
      nrst  = ($urandom_range(0, 199) != 0);
      flush = ($urandom_range(0, 39) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if (!hold_req) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = DW'($urandom);
      end
      next();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
